// File: rtl/mole_led_output_pkg.sv
// Shared constants, key range and FSM encoding for the whack-a-mole LED output block.
// Key indices are 1-based on the wire; LED bit (key-1) lights the matching mole.
package mole_led_output_pkg;

    localparam int NUM_KEYS      = 11;
    localparam int CYCLES_PER_MS = 1000;

    localparam logic [3:0] KEY_MIN = 4'd1;
    localparam logic [3:0] KEY_MAX = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic key_valid(input logic [3:0] key);
        return (key >= KEY_MIN) && (key <= KEY_MAX);
    endfunction

endpackage

// File: rtl/mole_led_output_ms_tick_gen.sv
// Millisecond prescaler: counts 0..CYCLES_PER_MS-1 and wraps; tick marks the last count.
// clear holds the count at zero so a new display starts on a full millisecond.
module ms_tick_gen #(
    parameter int CYCLES_PER_MS = mole_led_output_pkg::CYCLES_PER_MS
) (
    input  logic clk_1mhz,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_MS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/mole_led_output.sv
// Lights one mole LED for a requested number of ms, ending early on a matching key hit.
// Single outstanding request: show_ready is low from acceptance until the DONE cycle has passed.
module mole_led_output #(
    parameter int NUM_KEYS      = mole_led_output_pkg::NUM_KEYS,
    parameter int CYCLES_PER_MS = mole_led_output_pkg::CYCLES_PER_MS
) (
    input  logic                clk_1mhz,
    input  logic                rst,
    input  logic                show_valid,
    input  logic [3:0]          show_value,
    input  logic [9:0]          show_ms,
    output logic                show_ready,
    input  logic                hit_pressed,
    input  logic [3:0]          hit_value,
    output logic [NUM_KEYS-1:0] led_out,
    output logic                done_pulse,
    output logic                done_hit,
    output logic                err_pulse
);
    import mole_led_output_pkg::*;

    localparam logic [NUM_KEYS-1:0] LED_ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [3:0] cur_key;
    logic [9:0] ms_left;
    logic       tick;
    logic       clear_ps;
    logic       hit_match;
    logic       timeout;

    // Prescaler only runs while showing, so every display starts at count 0.
    assign clear_ps  = (state != ST_SHOW);
    assign hit_match = (state == ST_SHOW) && hit_pressed && (hit_value == cur_key);
    assign timeout   = (state == ST_SHOW) && tick && (ms_left == 10'd1);

    ms_tick_gen #(
        .CYCLES_PER_MS (CYCLES_PER_MS)
    ) u_ms_tick_gen (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .clear    (clear_ps),
        .tick     (tick)
    );

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            led_out    <= '0;
            cur_key    <= '0;
            ms_left    <= '0;
            show_ready <= 1'b0;
            done_pulse <= 1'b0;
            done_hit   <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    led_out <= '0;
                    if (show_valid && key_valid(show_value)) begin
                        led_out    <= LED_ONE << (show_value - KEY_MIN);
                        cur_key    <= show_value;
                        ms_left    <= (show_ms == 10'd0) ? 10'd1 : show_ms;
                        show_ready <= 1'b0;
                        state      <= ST_SHOW;
                    end else begin
                        show_ready <= 1'b1;
                        err_pulse  <= show_valid;
                    end
                end
                ST_SHOW: begin
                    show_ready <= 1'b0;
                    // A hit on the final tick still counts as a hit.
                    if (hit_match || timeout) begin
                        led_out    <= '0;
                        done_pulse <= 1'b1;
                        done_hit   <= hit_match;
                        state      <= ST_DONE;
                    end else if (tick) begin
                        ms_left <= ms_left - 10'd1;
                    end
                end
                ST_DONE: begin
                    led_out    <= '0;
                    show_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    led_out    <= '0;
                    show_ready <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_led_output.sv
// Directed bench for mole_led_output: timeout, hit, wrong key, invalid request, reset, back-to-back.
`timescale 1ns/1ps
module tb_mole_led_output;

    logic        clk_1mhz = 1'b0;
    logic        rst = 1'b1;
    logic        show_valid = 1'b0;
    logic [3:0]  show_value = 4'd0;
    logic [9:0]  show_ms = 10'd0;
    logic        show_ready;
    logic        hit_pressed = 1'b0;
    logic [3:0]  hit_value = 4'd0;
    logic [10:0] led_out;
    logic        done_pulse;
    logic        done_hit;
    logic        err_pulse;

    int total = 0;
    int bad = 0;

    mole_led_output dut (
        .clk_1mhz    (clk_1mhz),
        .rst         (rst),
        .show_valid  (show_valid),
        .show_value  (show_value),
        .show_ms     (show_ms),
        .show_ready  (show_ready),
        .hit_pressed (hit_pressed),
        .hit_value   (hit_value),
        .led_out     (led_out),
        .done_pulse  (done_pulse),
        .done_hit    (done_hit),
        .err_pulse   (err_pulse)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_1mhz);
        total++; if (led_out !== 11'd0) begin bad++; $display("FAIL reset_led: got %h want 000", led_out); end
        total++; if (show_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", show_ready); end
        total++; if (done_pulse !== 1'b0) begin bad++; $display("FAIL reset_done_pulse: got %b want 0", done_pulse); end
        total++; if (done_hit !== 1'b0) begin bad++; $display("FAIL reset_done_hit: got %b want 0", done_hit); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_pulse); end
        rst = 1'b0;
        @(negedge clk_1mhz);
        total++; if (show_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", show_ready); end
    endtask

    task automatic test_timeout();
        int lit = 0;
        int wrong = 0;
        show_valid = 1'b1; show_value = 4'd5; show_ms = 10'd3;
        @(negedge clk_1mhz);
        show_valid = 1'b0;
        total++; if (led_out !== 11'b000_0001_0000) begin bad++; $display("FAIL timeout_led: got %b want 00000010000", led_out); end
        total++; if (show_ready !== 1'b0) begin bad++; $display("FAIL timeout_busy_ready: got %b want 0", show_ready); end
        while (led_out !== 11'd0 && lit < 4000) begin
            if (led_out !== 11'b000_0001_0000) wrong++;
            lit++;
            @(negedge clk_1mhz);
        end
        total++; if (lit !== 3000) begin bad++; $display("FAIL timeout_lit_cycles: got %0d want 3000", lit); end
        total++; if (wrong !== 0) begin bad++; $display("FAIL timeout_led_stable: got %0d bad cycles want 0", wrong); end
        total++; if (done_pulse !== 1'b1) begin bad++; $display("FAIL timeout_done_pulse: got %b want 1", done_pulse); end
        total++; if (done_hit !== 1'b0) begin bad++; $display("FAIL timeout_done_hit: got %b want 0", done_hit); end
        @(negedge clk_1mhz);
        total++; if (done_pulse !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width: got %b want 0", done_pulse); end
        total++; if (show_ready !== 1'b1) begin bad++; $display("FAIL timeout_ready_back: got %b want 1", show_ready); end
    endtask

    task automatic test_wrong_key();
        int early = 0;
        show_valid = 1'b1; show_value = 4'd2; show_ms = 10'd1;
        @(negedge clk_1mhz);
        show_valid = 1'b0;
        hit_pressed = 1'b1; hit_value = 4'd3;
        total++; if (led_out !== 11'b000_0000_0010) begin bad++; $display("FAIL wrongkey_led: got %b want 00000000010", led_out); end
        for (int k = 2; k <= 1000; k++) begin
            @(negedge clk_1mhz);
            if (led_out !== 11'b000_0000_0010 || done_pulse !== 1'b0) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL wrongkey_no_early_end: got %0d bad cycles want 0", early); end
        hit_value = 4'd2;
        @(negedge clk_1mhz);
        total++; if (done_pulse !== 1'b1) begin bad++; $display("FAIL hitwins_done_pulse: got %b want 1", done_pulse); end
        total++; if (done_hit !== 1'b1) begin bad++; $display("FAIL hitwins_done_hit: got %b want 1", done_hit); end
        total++; if (led_out !== 11'd0) begin bad++; $display("FAIL hitwins_led: got %b want 0", led_out); end
        hit_pressed = 1'b0; hit_value = 4'd0;
        @(negedge clk_1mhz);
        total++; if (show_ready !== 1'b1) begin bad++; $display("FAIL hitwins_ready: got %b want 1", show_ready); end
    endtask

    task automatic test_invalid();
        logic [3:0] bad_vals [3] = '{4'd0, 4'd12, 4'd15};
        int lit = 0;
        int wrong = 0;
        for (int i = 0; i < 3; i++) begin
            show_valid = 1'b1; show_value = bad_vals[i]; show_ms = 10'd4;
            @(negedge clk_1mhz);
            show_valid = 1'b0;
            total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL invalid_err value=%0d: got %b want 1", bad_vals[i], err_pulse); end
            total++; if (led_out !== 11'd0) begin bad++; $display("FAIL invalid_led value=%0d: got %b want 0", bad_vals[i], led_out); end
            total++; if (show_ready !== 1'b1) begin bad++; $display("FAIL invalid_ready value=%0d: got %b want 1", bad_vals[i], show_ready); end
            @(negedge clk_1mhz);
            total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL invalid_err_width value=%0d: got %b want 0", bad_vals[i], err_pulse); end
        end
        show_valid = 1'b1; show_value = 4'd1; show_ms = 10'd0;
        @(negedge clk_1mhz);
        show_valid = 1'b0;
        while (led_out !== 11'd0 && lit < 2000) begin
            if (led_out !== 11'b000_0000_0001) wrong++;
            lit++;
            @(negedge clk_1mhz);
        end
        total++; if (lit !== 1000) begin bad++; $display("FAIL ms0_lit_cycles: got %0d want 1000", lit); end
        total++; if (wrong !== 0) begin bad++; $display("FAIL ms0_led_stable: got %0d bad cycles want 0", wrong); end
        total++; if (done_pulse !== 1'b1 || done_hit !== 1'b0) begin bad++; $display("FAIL ms0_done: got pulse=%b hit=%b want 1 0", done_pulse, done_hit); end
        @(negedge clk_1mhz);
    endtask

    task automatic test_hit();
        show_valid = 1'b1; show_value = 4'd11; show_ms = 10'd100;
        @(negedge clk_1mhz);
        show_valid = 1'b0;
        total++; if (led_out !== 11'b100_0000_0000) begin bad++; $display("FAIL hit_led: got %b want 10000000000", led_out); end
        repeat (499) @(negedge clk_1mhz);
        total++; if (led_out !== 11'b100_0000_0000 || done_pulse !== 1'b0) begin bad++; $display("FAIL hit_prewindow: got led=%b pulse=%b want 10000000000 0", led_out, done_pulse); end
        hit_pressed = 1'b1; hit_value = 4'd11;
        @(negedge clk_1mhz);
        total++; if (led_out !== 11'd0) begin bad++; $display("FAIL hit_led_clear: got %b want 0", led_out); end
        total++; if (done_pulse !== 1'b1) begin bad++; $display("FAIL hit_done_pulse: got %b want 1", done_pulse); end
        total++; if (done_hit !== 1'b1) begin bad++; $display("FAIL hit_done_hit: got %b want 1", done_hit); end
        hit_pressed = 1'b0; hit_value = 4'd0;
        @(negedge clk_1mhz);
        total++; if (done_pulse !== 1'b0 || show_ready !== 1'b1) begin bad++; $display("FAIL hit_after: got pulse=%b ready=%b want 0 1", done_pulse, show_ready); end
        total++; if (done_hit !== 1'b1) begin bad++; $display("FAIL hit_hold: got %b want 1", done_hit); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        show_valid = 1'b1; show_value = 4'd7; show_ms = 10'd5;
        @(negedge clk_1mhz);
        show_valid = 1'b0;
        repeat (699) @(negedge clk_1mhz);
        total++; if (led_out !== 11'b000_0100_0000) begin bad++; $display("FAIL rstmid_led_before: got %b want 00001000000", led_out); end
        rst = 1'b1;
        #1;
        total++; if (led_out !== 11'd0) begin bad++; $display("FAIL rstmid_async_led: got %b want 0", led_out); end
        total++; if (show_ready !== 1'b0 || done_hit !== 1'b0) begin bad++; $display("FAIL rstmid_async_regs: got ready=%b hit=%b want 0 0", show_ready, done_hit); end
        repeat (2) begin
            @(negedge clk_1mhz);
            if (done_pulse !== 1'b0) pulses++;
        end
        rst = 1'b0;
        @(negedge clk_1mhz);
        if (done_pulse !== 1'b0) pulses++;
        total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", pulses); end
        total++; if (show_ready !== 1'b1 || led_out !== 11'd0) begin bad++; $display("FAIL rstmid_release: got ready=%b led=%b want 1 0", show_ready, led_out); end
    endtask

    task automatic test_back_to_back();
        logic led_s [2100];
        logic dp_s  [2100];
        logic rdy_s [2100];
        int lit1 = 0;
        int lit2 = 0;
        int dps = 0;
        int wait_cnt = 0;
        show_valid = 1'b1; show_value = 4'd1; show_ms = 10'd1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk_1mhz);
            led_s[i] = (led_out === 11'b000_0000_0001);
            dp_s[i]  = done_pulse;
            rdy_s[i] = show_ready;
        end
        show_valid = 1'b0;
        for (int i = 0; i < 1000; i++) if (led_s[i]) lit1++;
        for (int i = 1002; i < 2002; i++) if (led_s[i]) lit2++;
        for (int i = 0; i < 2100; i++) if (dp_s[i] === 1'b1) dps++;
        total++; if (lit1 !== 1000) begin bad++; $display("FAIL b2b_window1: got %0d want 1000", lit1); end
        total++; if (dp_s[1000] !== 1'b1 || led_s[1000] !== 1'b0) begin bad++; $display("FAIL b2b_done1: got pulse=%b led=%b want 1 0", dp_s[1000], led_s[1000]); end
        total++; if (rdy_s[1001] !== 1'b1 || led_s[1001] !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got ready=%b led=%b want 1 0", rdy_s[1001], led_s[1001]); end
        total++; if (lit2 !== 1000) begin bad++; $display("FAIL b2b_window2: got %0d want 1000", lit2); end
        total++; if (dp_s[2002] !== 1'b1) begin bad++; $display("FAIL b2b_done2: got %b want 1", dp_s[2002]); end
        total++; if (dps !== 2) begin bad++; $display("FAIL b2b_pulse_count: got %0d want 2", dps); end
        while (show_ready !== 1'b1 && wait_cnt < 1100) begin
            @(negedge clk_1mhz);
            wait_cnt++;
        end
        total++; if (show_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain: got ready=%b want 1", show_ready); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_wrong_key();
        test_invalid();
        test_hit();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
